// File: rtl/multi_y_range_checker.sv
// Per-line vertical span checker: at each horizontal blank, tests NUM_OBJ objects against the
// next line using one shared comparator, then publishes all flags in a single update.
module multi_y_range_checker #(
   parameter int V_CNT_WID  = 10,
   parameter int POS_WID    = 10,
   parameter int HEIGHT_WID = 8,
   parameter int NUM_OBJ    = 3
) (
   input  logic                          CLK,
   input  logic                          RST,
   input  logic                          H_BLANK,
   input  logic [V_CNT_WID-1:0]          nextY,
   input  logic [NUM_OBJ*POS_WID-1:0]    objPos,
   input  logic [NUM_OBJ*HEIGHT_WID-1:0] objHeight,
   input  logic [NUM_OBJ-1:0]            objEnable,
   output logic [NUM_OBJ-1:0]            isObjY,
   output logic                          resultValid,
   output logic                          busy,
   output logic                          overrun
);

   // state    | meaning
   // IDLE     | waiting for blanking to start
   // LATCH    | capture nextY, reset index and overrun flag
   // CALC     | test one object per cycle into shadow
   // COMMIT   | publish shadow to isObjY, pulse resultValid
   // WAIT_LOW | hold until blanking ends (one sweep per interval)

   localparam int MAX_VP  = (V_CNT_WID > POS_WID) ? V_CNT_WID : POS_WID;
   localparam int CMP_WID = ((MAX_VP > HEIGHT_WID) ? MAX_VP : HEIGHT_WID) + 1;
   localparam int IDX_WID = (NUM_OBJ > 1) ? $clog2(NUM_OBJ) : 1;
   localparam logic [IDX_WID-1:0] LAST_IDX = IDX_WID'(NUM_OBJ - 1);

   typedef enum logic [4:0] {
      IDLE     = 5'b00001,
      LATCH    = 5'b00010,
      CALC     = 5'b00100,
      COMMIT   = 5'b01000,
      WAIT_LOW = 5'b10000
   } state_t;

   state_t                 state, stateNext;
   logic                   hBlankBuf;
   logic [IDX_WID-1:0]     idx;
   logic [V_CNT_WID-1:0]   drawY;
   logic [NUM_OBJ-1:0]     shadow;
   logic                   ovrFlag;

   logic [POS_WID-1:0]     posSel;
   logic [HEIGHT_WID-1:0]  heightSel;
   logic                   enSel;
   logic [CMP_WID-1:0]     lo, hi, drawExt;
   logic                   hit;

   always_ff @(posedge CLK) begin
      if (RST) state <= IDLE;
      else     state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      unique case (state)
         IDLE:     if (hBlankBuf) stateNext = LATCH;
         LATCH:    stateNext = CALC;
         CALC:     if (idx == LAST_IDX) stateNext = COMMIT;
         COMMIT:   stateNext = WAIT_LOW;
         WAIT_LOW: if (!hBlankBuf) stateNext = IDLE;
         default:  stateNext = IDLE;
      endcase
   end

   always_comb begin
      busy = 1'b0;
      unique case (state)
         LATCH, CALC, COMMIT: busy = 1'b1;
         default:             busy = 1'b0;
      endcase
   end

   // Index mux written as a loop so a non-power-of-two NUM_OBJ never reads past the bus.
   always_comb begin
      posSel    = '0;
      heightSel = '0;
      enSel     = 1'b0;
      for (int i = 0; i < NUM_OBJ; i++) begin
         if (idx == IDX_WID'(i)) begin
            posSel    = objPos[i*POS_WID +: POS_WID];
            heightSel = objHeight[i*HEIGHT_WID +: HEIGHT_WID];
            enSel     = objEnable[i];
         end
      end
   end

   // One extra bit keeps pos+height from wrapping past the top of the line counter.
   assign lo      = CMP_WID'(posSel);
   assign hi      = lo + CMP_WID'(heightSel);
   assign drawExt = CMP_WID'(drawY);
   assign hit     = enSel && (drawExt >= lo) && (drawExt < hi);

   always_ff @(posedge CLK) begin
      if (RST) begin
         hBlankBuf   <= 1'b0;
         idx         <= '0;
         drawY       <= '0;
         shadow      <= '0;
         isObjY      <= '0;
         resultValid <= 1'b0;
         overrun     <= 1'b0;
         ovrFlag     <= 1'b0;
      end else begin
         hBlankBuf   <= H_BLANK;
         resultValid <= 1'b0;
         overrun     <= 1'b0;
         unique case (state)
            LATCH: begin
               drawY   <= nextY;
               idx     <= '0;
               ovrFlag <= !hBlankBuf;
            end
            CALC: begin
               for (int i = 0; i < NUM_OBJ; i++) begin
                  if (idx == IDX_WID'(i)) shadow[i] <= hit;
               end
               ovrFlag <= ovrFlag | !hBlankBuf;
               if (idx != LAST_IDX) idx <= idx + 1'b1;
            end
            COMMIT: begin
               isObjY      <= shadow;
               resultValid <= 1'b1;
               overrun     <= ovrFlag;
            end
            default: ;
         endcase
      end
   end

endmodule
